// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int unsigned NDIGITS = 4;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_e;

    localparam logic [NDIGITS-1:0] AN_OFF = 4'b1111;
    localparam logic [NDIGITS-1:0] AN_ONE = 4'b0001;

    // Active-low one-hot anode pattern selecting digit idx.
    function automatic logic [NDIGITS-1:0] an_onehot(input logic [1:0] idx);
        return ~(AN_ONE << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Free-running slot counter; flags the last blank cycle and the last slot cycle.
module slot_timer #(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000,
    parameter int unsigned CNT_BITS     = 17
) (
    input  logic clk,
    input  logic rst,
    output logic blank_end,
    output logic slot_end
);

    localparam logic [CNT_BITS-1:0] CNT_LAST   = CNT_BITS'(TICK_DIV - 1);
    localparam logic [CNT_BITS-1:0] BLANK_LAST = CNT_BITS'(BLANK_CYCLES - 1);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_BITS'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_end = (cnt_q == BLANK_LAST);
    assign slot_end  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Basys3 4-digit seven-segment scan controller with frame-synchronous load port.
// Optional leading-zero blanking is enabled by defining SEGSCAN_LZB_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000,
    parameter int unsigned CNT_BITS     = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    state_e      state_q, state_d;
    logic [1:0]  dig_q, dig_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  hold_dp_q, hold_dp_d;
    logic        hold_full_q, hold_full_d;
    logic        boundary_q, boundary_d;
    logic        frame_start_q, frame_start_d;
    logic        blank_end, slot_end;
    logic        digit_on;

    slot_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_BITS     (CNT_BITS)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    always_comb begin
        state_d       = state_q;
        dig_d         = dig_q;
        disp_d        = disp_q;
        disp_dp_d     = disp_dp_q;
        hold_d        = hold_q;
        hold_dp_d     = hold_dp_q;
        hold_full_d   = hold_full_q;
        boundary_d    = 1'b0;
        frame_start_d = boundary_q;

        case (state_q)
            ST_BLANK: begin
                if (blank_end) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (slot_end) begin
                    state_d    = ST_BLANK;
                    dig_d      = dig_q + 2'd1;
                    boundary_d = (dig_q == 2'(NDIGITS - 1));
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // Commit only fires when the holder is full, and a transfer only when it
        // is empty, so the two can never collide on the same data.
        if (boundary_q && hold_full_q) begin
            disp_d      = hold_q;
            disp_dp_d   = hold_dp_q;
            hold_full_d = 1'b0;
        end else if (load_valid && !hold_full_q) begin
            hold_d      = load_data;
            hold_dp_d   = load_dp;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            dig_q         <= '0;
            disp_q        <= '0;
            disp_dp_q     <= '0;
            hold_q        <= '0;
            hold_dp_q     <= '0;
            hold_full_q   <= 1'b0;
            boundary_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dig_q         <= dig_d;
            disp_q        <= disp_d;
            disp_dp_q     <= disp_dp_d;
            hold_q        <= hold_d;
            hold_dp_q     <= hold_dp_d;
            hold_full_q   <= hold_full_d;
            boundary_q    <= boundary_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef SEGSCAN_LZB_EN
    logic [1:0] msd;

    always_comb begin
        msd = '0;
        for (int unsigned i = 1; i < NDIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                msd = 2'(i);
            end
        end
    end

    assign digit_on = (dig_q <= msd);
`else
    assign digit_on = 1'b1;
`endif

    always_comb begin
        an  = AN_OFF;
        hex = '0;
        dp  = 1'b1;
        if (state_q == ST_DRIVE && digit_on) begin
            an  = an_onehot(dig_q);
            hex = disp_q[4*dig_q +: 4];
            dp  = ~disp_dp_q[dig_q];
        end
    end

    assign load_ready  = ~hold_full_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model plus directed literals.
module tb_seg_scan_ctrl;

    localparam int unsigned TD    = 8;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = 4 * TD;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int n_total = 0;
    int n_pass  = 0;

    seg_scan_ctrl #(
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC),
        .CNT_BITS     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .hex         (hex),
        .an          (an),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset, displayed value and the single-entry holder.
    int unsigned t;
    logic [15:0] m_disp, m_hold;
    logic [3:0]  m_dpd, m_hdp;
    bit          m_full;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t      <= 0;
            m_disp <= '0;
            m_dpd  <= '0;
            m_full <= 1'b0;
            m_ok   <= 1'b1;
        end else if (m_ok) begin
            if (t % FRAME == 0 && m_full) begin
                m_disp <= m_hold;
                m_dpd  <= m_hdp;
                m_full <= 1'b0;
            end else if (load_valid && !m_full) begin
                m_hold <= load_data;
                m_hdp  <= load_dp;
                m_full <= 1'b1;
            end
            t <= t + 1;
        end
    end

    function automatic logic [10:0] expected_outputs();
        int unsigned p, d, w;
        logic [3:0]  e_an, e_hex;
        logic        e_dp, drive;
        logic [15:0] upper;
        p     = t % FRAME;
        d     = p / TD;
        w     = p % TD;
        e_an  = 4'b1111;
        e_hex = 4'h0;
        e_dp  = 1'b1;
        drive = (w >= BC);
        upper = m_disp >> (4 * d);
`ifdef SEGSCAN_LZB_EN
        if (d > 0 && upper == 16'h0) drive = 1'b0;
`endif
        if (drive) begin
            e_an  = ~(4'(1) << d);
            e_hex = upper[3:0];
            e_dp  = ~m_dpd[d];
        end
        return {e_an, e_hex, e_dp, (p == 1), ~m_full};
    endfunction

    always @(negedge clk) begin
        if (m_ok) begin
            chk("outputs{an,hex,dp,fs,rdy}", {21'b0, an, hex, dp, frame_start, load_ready},
                {21'b0, expected_outputs()});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] p);
        int k;
        load_valid = 1'b1;
        load_data  = d;
        load_dp    = p;
        k = 0;
        while (load_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("send_accept", {31'b0, load_ready}, 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        while (frame_start !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("frame_start_seen", {31'b0, frame_start}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_dp    = '0;

        step(3);
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_dp_hex_rdy", {26'b0, dp, hex, load_ready}, {26'b0, 1'b1, 4'h0, 1'b1});
        rst = 1'b0;
        chk("fs_release_cycle", {31'b0, frame_start}, 32'd0);
        step(1);
        chk("fs_first_pulse", {31'b0, frame_start}, 32'd1);

        // Scan order
        send(16'h4321, 4'b0000);
        wait_fs();
        step(1);      chk("scan_d0", {24'b0, an, hex}, {24'b0, 4'b1110, 4'h1});
        step(TD);     chk("scan_d1", {24'b0, an, hex}, {24'b0, 4'b1101, 4'h2});
        step(TD);     chk("scan_d2", {24'b0, an, hex}, {24'b0, 4'b1011, 4'h3});
        step(TD);     chk("scan_d3", {24'b0, an, hex}, {24'b0, 4'b0111, 4'h4});

        // No tearing
        send(16'hABCD, 4'b0000);
        chk("tear_ready_low", {31'b0, load_ready}, 32'd0);
        chk("tear_old_hex", {28'b0, hex}, 32'h4);
        wait_fs();
        chk("tear_ready_at_fs", {31'b0, load_ready}, 32'd1);
        step(1);      chk("tear_new_hex", {28'b0, hex}, 32'hD);

        // Backpressure
        send(16'h1111, 4'b0000);
        send(16'h2222, 4'b0000);
        chk("bp_first_shown", {28'b0, hex}, 32'h1);
        wait_fs();
        step(1);      chk("bp_second_shown", {28'b0, hex}, 32'h2);

        // Decimal point
        send(16'h5678, 4'b0100);
        wait_fs();
        step(TD + 1); chk("dp_d1_off", {27'b0, an, dp}, {27'b0, 4'b1101, 1'b1});
        step(TD);     chk("dp_d2_on", {27'b0, an, dp}, {27'b0, 4'b1011, 1'b0});

        // Leading zeros
        send(16'h0050, 4'b0000);
        wait_fs();
        step(1);      chk("lz_d0", {24'b0, an, hex}, {24'b0, 4'b1110, 4'h0});
        step(TD);     chk("lz_d1", {24'b0, an, hex}, {24'b0, 4'b1101, 4'h5});
        step(TD);
`ifdef SEGSCAN_LZB_EN
        chk("lz_d2", {28'b0, an}, 32'hF);
`else
        chk("lz_d2", {28'b0, an}, {28'b0, 4'b1011});
`endif
        send(16'h0000, 4'b0000);
        wait_fs();
        step(1);      chk("zero_d0", {24'b0, an, hex}, {24'b0, 4'b1110, 4'h0});
        step(TD);
`ifdef SEGSCAN_LZB_EN
        chk("zero_d1", {28'b0, an}, 32'hF);
`else
        chk("zero_d1", {28'b0, an}, {28'b0, 4'b1101});
`endif

        // Reset discards a held value
        send(16'h9999, 4'b1111);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_held_ready", {31'b0, load_ready}, 32'd1);
        wait_fs();
        step(1);      chk("rst_held_dropped", {24'b0, an, hex}, {24'b0, 4'b1110, 4'h0});

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 399) == 0);
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            load_dp    = 4'($urandom);
        end
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        step(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the Basys3 4-digit seven-segment display. It owns the anode lines and sequences one shared hex-to-segment decoder across the four digits, inserting a dead-time blank between digits to prevent ghosting. A valid/ready load port lets an upstream producer, such as the UART receive path or a counter, post a new 16-bit value. That value is committed only at a frame boundary, so the display never shows a torn value.

## Interface

- `TICK_DIV`, default 100_000: clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_CYCLES`, default 1_000: cycles at the start of each slot with all anodes off. Legal range is 1 ≤ BLANK_CYCLES < TICK_DIV.
- `CNT_BITS`, default 17: width of the slot counter. Must hold TICK_DIV-1.

- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-high.
- `load_valid`, in, 1: producer offers `load_data` and `load_dp`.
- `load_ready`, out, 1: holding register empty; a transfer occurs when `load_valid` and `load_ready` are both high.
- `load_data`, in, 16: four hex nibbles; digit i = [4i+3:4i].
- `load_dp`, in, 4: per-digit decimal point, 1 = lit.
- `hex`, out, 4: nibble for the shared decoder.
- `an`, out, 4: anodes, active-low.
- `dp`, out, 1: decimal point, active-low.
- `frame_start`, out, 1: one-cycle pulse at each frame boundary (commit point).

## Operation

**State machine** (`ST_BLANK`, `ST_DRIVE`):
- **Counters:**
  - Slot counter `cnt` runs 0..TICK_DIV-1, then wraps to 0.
  - Digit index `dig` runs 0..3, then wraps to 0.
- **ST_BLANK:** `an`=4'b1111, `dp`=1. At `cnt`=BLANK_CYCLES-1, go to ST_DRIVE.
- **ST_DRIVE:**
  - Outputs: `an` has bit `dig` low and all others high; `hex`=display nibble `dig`; `dp`=~disp_dp[`dig`].
  - At `cnt`=TICK_DIV-1, go to ST_BLANK, set `cnt`=0 and `dig`=`dig`+1 (wrapping).
- **Frame boundary:** the cycle where ST_BLANK is entered with `dig`=0 (and the first cycle after reset).
  - If the holding register is full, copy it to the display register and clear the holding register.
  - Pulse `frame_start` on every frame boundary, whether or not a commit occurs.

**Load port:**
- `load_ready` = holding register empty.
- On a transfer, capture `load_data` and `load_dp` into the holding register.
- A producer that keeps `load_valid` high after its transfer waits until the next commit before the next transfer.
- **Simultaneous load and commit:** if a transfer and a commit fall in the same cycle, the holding register must have been empty, so the commit has nothing to copy. The new data stays held and commits at the next boundary.
- A held value is never overwritten; a newer value waits for `load_ready`.

**Reset** (`rst` high; synchronous):
- Registers: `cnt`=0, `dig`=0, state ST_BLANK, display register 16'h0000 and dp 4'b0000, holding register empty.
- Outputs: `an`=4'b1111, `hex`=0, `dp`=1, `frame_start`=0, `load_ready`=1.
- Loads presented while `rst` is high are ignored.
- Reset mid-frame abandons the slot. A held (uncommitted) value is discarded.

## Timing

- All outputs are registered or decoded from registered state; there are no combinational paths from `load_*` to display outputs.
- Slot length is exactly TICK_DIV cycles: BLANK_CYCLES blank, then TICK_DIV-BLANK_CYCLES driven.
- Frame length is 4·TICK_DIV cycles.
- Accept-to-display latency:
  - Minimum: 1 cycle to the commit, plus BLANK_CYCLES until digit 0 drives.
  - Maximum: 4·TICK_DIV+BLANK_CYCLES.
- `frame_start` is asserted for 1 cycle in the commit cycle. It is not asserted on the cycle reset deasserts; the first pulse follows one cycle later.

## Configuration

`SEGSCAN_LZB_EN`:
- **Defined (leading-zero blanking):**
  - In ST_DRIVE, each digit above the most-significant nonzero nibble of the display register keeps `an` all-high and `dp`=1.
  - Digit 0 is always driven, so a value of 0 shows a single "0".
  - Slot timing is unchanged.
- **Undefined:** all four digits are driven every frame.

## Structure

- **Package `seg_scan_pkg`:**
  - NDIGITS=4.
  - State enum {ST_BLANK, ST_DRIVE}.
  - Constant AN_OFF=4'b1111.
  - Function returning the active-low one-hot anode pattern for a digit index.
- **Sub-module `slot_timer`:**
  - Contains the `cnt` counter.
  - Outputs `blank_end` (`cnt`=BLANK_CYCLES-1) and `slot_end` (`cnt`=TICK_DIV-1).
  - The FSM, holding/display registers and LZB logic stay in the top module.

## Test plan

Bench parameters: TICK_DIV=8, BLANK_CYCLES=2.

- **Reset:** hold `rst` high for 3 cycles → `an`=1111, `dp`=1, `hex`=0, `load_ready`=1; after release, `frame_start` pulses the following cycle.
- **Scan order:** load 16'h4321, dp 4'b0000 → after commit, `an` sequences 1110/1101/1011/0111, each for 6 cycles, with 2 cycles of 1111 between. `hex` reads 1, 2, 3, 4.
- **No tearing:** load 16'hABCD mid-frame → digits keep the old value until the next `frame_start`; `load_ready` stays low until that cycle.
- **Backpressure:** hold `load_valid` with 16'h1111, then 16'h2222 → the second transfer occurs only after the first commits; 16'h2222 is displayed one frame later.
- **Decimal point:** load_dp 4'b0100 → `dp`=0 only while `an`=1011.
- **Leading-zero blanking:** with SEGSCAN_LZB_EN, load 16'h0050 → digits 3 and 2 stay off, digit 1 shows 5, digit 0 shows 0. Load 16'h0000 → only digit 0 drives.
